// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier operand sequencer and its FIFO.
package mul_pkg;
  localparam int MUL_W       = 16;
  localparam int MUL_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    DRAIN
  } seq_state_t;
endpackage

// File: rtl/mul_operand_sequencer_fifo.sv
// Synchronous operand-pair FIFO: registered storage, first-word-fall-through read port.
module op_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds buffered operand pairs to the shift/add multiplier core in its start/A/B load
// order, waits for done (with a watchdog) and returns the product on a valid/ready stream.
module mul_operand_sequencer
  import mul_pkg::*;
#(
  parameter int W       = MUL_W,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = MUL_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_done,
  input  logic [W-1:0] mul_prod,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_err
);
  // Handshakes: a transfer occurs on a rising edge where valid && ready; valid never
  // depends on ready, and payload is held stable while valid is high and ready is low.
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  seq_state_t state;
  seq_state_t next_state;

  logic [W-1:0]    cur_a;
  logic [W-1:0]    cur_b;
  logic [WD_W-1:0] wd;
  logic            wd_expired;
  logic            cap_prod;
  logic            cap_err;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [2*W-1:0]  fifo_rdata;

  assign in_ready   = (fifo_count != FULL_CNT);
  assign fifo_push  = in_valid && !fifo_full;
  assign wd_expired = (wd == WD_MAX);

  op_fifo #(
    .W     (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({in_a, in_b}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    cap_prod   = 1'b0;
    cap_err    = 1'b0;
    mul_start  = 1'b0;
    mul_data   = '0;
    case (state)
      // A pending result or a still-high done from the last run blocks a new start.
      IDLE: begin
        if (!fifo_empty && !out_valid && !mul_done) begin
          next_state = START;
          fifo_pop   = 1'b1;
        end
      end
      START: begin
        mul_start  = 1'b1;
        next_state = LOAD_A;
      end
      LOAD_A: begin
        mul_data   = cur_a;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        mul_data   = cur_b;
        next_state = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          cap_prod   = 1'b1;
          next_state = DRAIN;
        end else if (wd_expired) begin
          cap_err    = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!mul_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_a     <= '0;
      cur_b     <= '0;
      wd        <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_err   <= 1'b0;
    end else begin
      if (fifo_pop) {cur_a, cur_b} <= fifo_rdata;

      if (state == LOAD_B) wd <= '0;
      else if (state == WAIT && !mul_done && !wd_expired) wd <= wd + 1'b1;

      // Done takes priority over a watchdog expiring in the same cycle.
      if (cap_prod) begin
        out_prod  <= mul_prod;
        out_err   <= 1'b0;
        out_valid <= 1'b1;
      end else if (cap_err) begin
        out_prod  <= '0;
        out_err   <= 1'b1;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed bench for mul_operand_sequencer with a behavioural multiplier core and a
// result scoreboard fed at push time and drained by an independent monitor.
module tb_mul_operand_sequencer;
  localparam int W       = 16;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 255;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         mul_start, mul_done;
  logic [W-1:0] mul_data, mul_prod;
  logic         out_valid, out_ready, out_err;
  logic [W-1:0] out_prod;

  mul_operand_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_start (mul_start),
    .mul_data  (mul_data),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_err   (out_err)
  );

  // scoreboard state
  logic [W:0]   exp_q[$];
  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // core model controls and observations
  int core_lat  = 10;
  int core_hold = 0;
  bit core_dead = 1'b0;
  int start_cyc = 0, prev_start = -100, done_cyc = 0, wait_cyc = 0, done_fall = -100;
  int n_starts = 0, n_waits = 0, n_results = 0, rise_cyc = 0, push_cyc = 0;

  initial begin : core_model
    logic [W-1:0] ca, cb, ea, eb;
    int  k;
    bit  abort;
    mul_done = 1'b0;
    mul_prod = '0;
    forever begin
      @(negedge clk);
      if (mul_start && !rst) begin
        n_starts++;
        chk("start_after_done", 32'(cyc >= done_fall + 2), 1);
        chk("start_spacing", 32'((cyc - prev_start) >= 6), 1);
        chk("data_in_start", 32'(mul_data), 0);
        prev_start = cyc;
        start_cyc  = cyc;
        @(negedge clk);
        chk("start_pulse", 32'(mul_start), 0);
        ca = mul_data;
        ea = (a_q.size() > 0) ? a_q.pop_front() : 'x;
        chk("load_a", 32'(ca), 32'(ea));
        @(negedge clk);
        cb = mul_data;
        eb = (b_q.size() > 0) ? b_q.pop_front() : 'x;
        chk("load_b", 32'(cb), 32'(eb));
        wait_cyc = cyc + 1;
        n_waits++;
        k = 0;
        abort = 1'b0;
        while (!abort && (core_dead || k < core_lat)) begin
          @(negedge clk);
          #1;
          k++;
          if (k == 1) chk("data_idle", 32'(mul_data), 0);
          if (rst || out_valid || k > 2000) abort = 1'b1;
        end
        if (!abort) begin
          mul_done = 1'b1;
          mul_prod = W'(ca * cb);
          done_cyc = cyc;
          repeat (1 + core_hold) @(negedge clk);
          mul_done  = 1'b0;
          done_fall = cyc;
        end
      end
    end
  end

  // monitor: result handshakes and hold stability
  initial begin : monitor
    logic         prev_valid, prev_hs, prev_rst, hs, prev_err;
    logic [W-1:0] prev_prod;
    logic [W:0]   exp_v;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_rst = 1'b1; prev_err = 1'b0; prev_prod = '0;
    forever begin
      @(negedge clk);
      #1;
      if (prev_valid && !prev_hs && !prev_rst) begin
        chk("valid_hold", 32'(out_valid), 1);
        chk("prod_hold", 32'(out_prod), 32'(prev_prod));
        chk("err_hold", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      hs = out_valid && out_ready;
      if (hs) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("result", 32'({out_err, out_prod}), 32'(exp_v));
        n_results++;
      end
      prev_valid = out_valid;
      prev_prod  = out_prod;
      prev_err   = out_err;
      prev_hs    = hs;
      prev_rst   = rst;
    end
  end

  // driver tasks; each is entered and left on a falling edge
  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp_v);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      push_cyc = cyc + 1;
      exp_q.push_back(exp_v);
      a_q.push_back(a);
      b_q.push_back(b);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (n_results < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("results_arrived", 32'(n_results >= n), 1);
  endtask

  initial begin : stimulus
    int s, k;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_mul_data", 32'(mul_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_prod", 32'(out_prod), 0);
    chk("rst_out_err", 32'(out_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // single pair 3*4
    core_lat = 10;
    push_pair(16'd3, 16'd4, 17'd12);
    s = push_cyc;
    wait_results(1, 100);
    chk("t1_start_latency", 32'(start_cyc - s), 1);
    chk("t1_done_to_valid", 32'(rise_cyc - done_cyc), 1);

    // backpressure, full FIFO, ordering
    out_ready = 1'b0;
    push_pair(16'd5, 16'd6, 17'd30);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t3_valid_up", 32'(out_valid), 1);
    push_pair(16'd100, 16'd200, 17'd20000);
    push_pair(16'hFFFF, 16'd2, 17'h0FFFE);
    chk("t2_full", 32'(in_ready), 0);
    s = n_starts;
    repeat (20) begin
      @(negedge clk);
      chk("t2_ready_low", 32'(in_ready), 0);
    end
    chk("t3_no_start", 32'(n_starts), 32'(s));
    out_ready = 1'b1;
    push_pair(16'd7, 16'd0, 17'd0);
    chk("t2_ready_at_start", 32'(push_cyc - 1), 32'(start_cyc));
    wait_results(5, 300);

    // core never completes
    core_dead = 1'b1;
    push_pair(16'd1, 16'd1, 17'h10000);
    wait_results(6, 400);
    chk("t4_timeout_cycles", 32'(rise_cyc - wait_cyc), 256);
    core_dead = 1'b0;

    // done held high after capture
    core_lat = 4;
    core_hold = 5;
    s = n_starts;
    push_pair(16'd9, 16'd9, 17'd81);
    push_pair(16'd11, 16'd3, 17'd33);
    wait_results(8, 300);
    repeat (10) @(negedge clk);
    chk("t5_starts", 32'(n_starts), 32'(s + 2));
    core_hold = 0;

    // reset during WAIT with one pair queued
    core_lat = 50;
    s = n_waits;
    push_pair(16'd2, 16'd2, 17'd4);
    push_pair(16'd3, 16'd3, 17'd9);
    k = 0;
    while (n_waits == s && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_wait", 32'(n_waits), 32'(s + 1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s = n_starts;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    a_q.delete();
    b_q.delete();
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_out_prod", 32'(out_prod), 0);
    chk("t6_fifo_empty", 32'(dut.u_fifo.empty), 1);
    repeat (30) @(negedge clk);
    chk("t6_no_start", 32'(n_starts), 32'(s));

    // recovery after reset
    core_lat = 3;
    push_pair(16'd13, 16'd5, 17'd65);
    wait_results(9, 100);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : global_timeout
    #300000;
    bad++;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
